// File: rtl/sdram_test_master.sv
// Write-then-readback memory tester driving the SDRAM controller's sys_* request port.
// Define SDRAM_TEST_LFSR_EN to replace the address-derived pattern with a 16-bit LFSR sequence.
module sdram_test_master #(
  parameter logic [21:0] START_ADDR  = 22'h000000,
  parameter logic [21:0] END_ADDR    = 22'h3FFFFF,
  parameter int unsigned TIMEOUT_CYC = 16384,
  parameter logic [15:0] PAT_SEED    = 16'hACE1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic [21:0] sys_addr,
  output logic [15:0] sys_data_to_sdram,
  output logic        sys_write_rq,
  output logic        sys_read_rq,
  input  logic [15:0] sys_data_from_sdram,
  input  logic        sys_data_from_sdram_valid,
  input  logic        sys_write_done,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] error_count,
  output logic [21:0] fail_addr,
  output logic [15:0] fail_exp,
  output logic [15:0] fail_got
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_CHK, FINISH} state_t;
  state_t state, state_nxt;

  logic [21:0]   addr_q;
  logic [15:0]   pat_q, rd_data_q;
  logic [TW-1:0] tmo_cnt;
  logic          wr_pend, rd_pend, last, tmo_hit;
  logic [21:0]   addr_inc;
  logic [15:0]   pat_first, pat_adv;

  assign last     = (addr_q == END_ADDR);
  assign addr_inc = addr_q + 22'd1;
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

`ifdef SDRAM_TEST_LFSR_EN
  // x^16+x^14+x^13+x^11+1, shifting right with feedback into bit 15
  assign pat_first = PAT_SEED;
  assign pat_adv   = {pat_q[0] ^ pat_q[2] ^ pat_q[3] ^ pat_q[5], pat_q[15:1]};
`else
  function automatic logic [15:0] pat_of(input logic [21:0] a);
    return a[15:0] ^ {10'b0, a[21:16]} ^ PAT_SEED;
  endfunction
  assign pat_first = pat_of(START_ADDR);
  assign pat_adv   = pat_of(addr_inc);
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = WR_REQ;
      WR_REQ:  if (sys_write_done) state_nxt = last ? RD_REQ : WR_REQ;
               else if (tmo_hit) state_nxt = FINISH;
      RD_REQ:  if (sys_data_from_sdram_valid) state_nxt = RD_CHK;
               else if (tmo_hit) state_nxt = FINISH;
      RD_CHK:  state_nxt = last ? FINISH : RD_REQ;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_pend = (state == WR_REQ);
    rd_pend = (state == RD_REQ);
    busy    = (state == WR_REQ) || (state == RD_REQ) || (state == RD_CHK);
  end

  // Gating by the completion pulse keeps the controller from seeing a stale request.
  assign sys_write_rq      = wr_pend & ~sys_write_done;
  assign sys_read_rq       = rd_pend & ~sys_data_from_sdram_valid;
  assign sys_addr          = busy ? addr_q : 22'h0;
  assign sys_data_to_sdram = busy ? pat_q  : 16'h0;
  assign pass              = done & (error_count == 16'h0) & ~timeout;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_q      <= START_ADDR;
      pat_q       <= PAT_SEED;
      rd_data_q   <= '0;
      tmo_cnt     <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      error_count <= '0;
      fail_addr   <= '0;
      fail_exp    <= '0;
      fail_got    <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          addr_q      <= START_ADDR;
          pat_q       <= pat_first;
          tmo_cnt     <= '0;
          done        <= 1'b0;
          timeout     <= 1'b0;
          error_count <= '0;
          fail_addr   <= '0;
          fail_exp    <= '0;
          fail_got    <= '0;
        end
        WR_REQ: begin
          if (sys_write_done) begin
            tmo_cnt <= '0;
            if (last) begin
              addr_q <= START_ADDR;
              pat_q  <= pat_first;
            end else begin
              addr_q <= addr_inc;
              pat_q  <= pat_adv;
            end
          end else if (tmo_hit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        end
        RD_REQ: begin
          if (sys_data_from_sdram_valid) rd_data_q <= sys_data_from_sdram;
          else if (tmo_hit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        end
        RD_CHK: begin
          if (rd_data_q != pat_q) begin
            if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
            if (error_count == 16'h0) begin
              fail_addr <= addr_q;
              fail_exp  <= pat_q;
              fail_got  <= rd_data_q;
            end
          end
          tmo_cnt <= '0;
          if (last) done <= 1'b1;
          else begin
            addr_q <= addr_inc;
            pat_q  <= pat_adv;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
